// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe automatic player.
// Holds the game_state encodings, the winning-line cell table, the fallback
// corner/edge move orders, the player FSM state type and cell-index helpers.
package ttt_pkg;

  typedef logic [3:0] cell_t;

  localparam logic [1:0] GS_PLAY  = 2'b00;
  localparam logic [1:0] GS_X_WIN = 2'b01;
  localparam logic [1:0] GS_O_WIN = 2'b10;
  localparam logic [1:0] GS_DRAW  = 2'b11;

  // Rows, then columns, then the two diagonals.
  localparam cell_t LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  localparam cell_t CORNERS [4] = '{4'd0, 4'd2, 4'd6, 4'd8};
  localparam cell_t EDGES   [4] = '{4'd1, 4'd3, 4'd5, 4'd7};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_PICK,
    S_ISSUE,
    S_WAIT
  } state_t;

  // Cell index 0..8 to 1-based row/column.
  function automatic logic [1:0] idx_to_row(input cell_t idx);
    cell_t q;
    q = idx / 4'd3;
    return q[1:0] + 2'd1;
  endfunction

  function automatic logic [1:0] idx_to_col(input cell_t idx);
    cell_t r;
    r = idx % 4'd3;
    return r[1:0] + 2'd1;
  endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Combinational evaluation of one winning line.
// Ports:
//   cell_valid  [2:0]  occupied flags of the three cells of the line
//   cell_symbol [2:0]  symbols of those cells (meaningful where valid)
//   my_sym             this player's symbol
//   own_cnt, opp_cnt   occupied cells holding own / opponent symbol
//   empty_pos          position (0..2) of the first empty cell in the line
//   has_empty          at least one empty cell in the line
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [2:0] cell_valid,
  input  logic [2:0] cell_symbol,
  input  logic       my_sym,
  output logic [1:0] own_cnt,
  output logic [1:0] opp_cnt,
  output logic [1:0] empty_pos,
  output logic       has_empty
);

  always_comb begin
    own_cnt   = '0;
    opp_cnt   = '0;
    empty_pos = '0;
    has_empty = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (cell_valid[i]) begin
        if (cell_symbol[i] == my_sym) own_cnt = own_cnt + 2'd1;
        else                          opp_cnt = opp_cnt + 2'd1;
      end else if (!has_empty) begin
        has_empty = 1'b1;
        empty_pos = 2'(i);
      end
    end
  end

endmodule

// File: rtl/ttt_auto_player.sv
// Automatic tic-tac-toe opponent driving the board's row/col/set interface.
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   enable                permits starting a move (looked at only in IDLE)
//   valid[8:0]            board cell-occupied flags, index (row-1)*3+(col-1)
//   symbol[8:0]           board cell symbols
//   game_state[1:0]       00 playing, 01 X wins, 10 O wins, 11 draw
//   row, col [1:0]        move coordinates 1..3, 00 when no move is presented
//   set                   one-cycle move strobe
//   busy                  high outside IDLE
//   move_done             one-cycle pulse once the target cell reads occupied
//   error                 sticky acknowledgement-timeout flag
module ttt_auto_player
  import ttt_pkg::*;
#(
  parameter bit          MY_SYMBOL = 1'b0,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [8:0] valid,
  input  logic [8:0] symbol,
  input  logic [1:0] game_state,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       set,
  output logic       busy,
  output logic       move_done,
  output logic       error
);

  state_t     state, state_nxt;
  logic [8:0] snap_valid, snap_valid_nxt;
  logic [8:0] snap_symbol, snap_symbol_nxt;
  logic [2:0] line_idx, line_idx_nxt;
  logic       win_found, win_found_nxt;
  logic       block_found, block_found_nxt;
  cell_t      win_cell, win_cell_nxt;
  cell_t      block_cell, block_cell_nxt;
  cell_t      target, target_nxt;
  logic [7:0] tmo_cnt, tmo_cnt_nxt;
  logic       move_done_nxt, error_nxt;

  logic       my_turn, playing;
  logic [3:0] n_occupied;
  cell_t      lcell [3];
  logic [2:0] lv, ls;
  logic [1:0] own_cnt, opp_cnt, empty_pos;
  logic       has_empty;
  cell_t      empty_cell;
  logic       pick_ok;
  cell_t      pick_cell;

  assign n_occupied = 4'($countones(valid));
  assign my_turn    = (n_occupied[0] == 1'b0) == (MY_SYMBOL == 1'b1);
  assign playing    = (game_state == GS_PLAY);

  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      lcell[k] = LINES[line_idx][k];
      lv[k]    = snap_valid[lcell[k]];
      ls[k]    = snap_symbol[lcell[k]];
    end
  end

  ttt_line_eval u_line_eval (
    .cell_valid  (lv),
    .cell_symbol (ls),
    .my_sym      (MY_SYMBOL),
    .own_cnt     (own_cnt),
    .opp_cnt     (opp_cnt),
    .empty_pos   (empty_pos),
    .has_empty   (has_empty)
  );

  always_comb begin
    case (empty_pos)
      2'd1:    empty_cell = lcell[1];
      2'd2:    empty_cell = lcell[2];
      default: empty_cell = lcell[0];
    endcase
  end

  // Move priority: win, block, centre, corners, edges (first free by snapshot).
  always_comb begin
    pick_ok   = 1'b0;
    pick_cell = '0;
    if (win_found) begin
      pick_ok   = 1'b1;
      pick_cell = win_cell;
    end else if (block_found) begin
      pick_ok   = 1'b1;
      pick_cell = block_cell;
    end else if (!snap_valid[4]) begin
      pick_ok   = 1'b1;
      pick_cell = 4'd4;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!pick_ok && !snap_valid[CORNERS[i]]) begin
          pick_ok   = 1'b1;
          pick_cell = CORNERS[i];
        end
      end
      for (int unsigned i = 0; i < 4; i++) begin
        if (!pick_ok && !snap_valid[EDGES[i]]) begin
          pick_ok   = 1'b1;
          pick_cell = EDGES[i];
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    snap_valid_nxt  = snap_valid;
    snap_symbol_nxt = snap_symbol;
    line_idx_nxt    = line_idx;
    win_found_nxt   = win_found;
    block_found_nxt = block_found;
    win_cell_nxt    = win_cell;
    block_cell_nxt  = block_cell;
    target_nxt      = target;
    tmo_cnt_nxt     = tmo_cnt;
    move_done_nxt   = 1'b0;
    error_nxt       = error;

    case (state)
      S_IDLE: begin
        // move_done high means our own move is still settling on the board.
        if (enable && playing && my_turn && (valid != '1) && !move_done) begin
          state_nxt       = S_SCAN;
          snap_valid_nxt  = valid;
          snap_symbol_nxt = symbol;
          line_idx_nxt    = '0;
          win_found_nxt   = 1'b0;
          block_found_nxt = 1'b0;
        end
      end
      S_SCAN: begin
        if (!playing) begin
          state_nxt = S_IDLE;
        end else if (valid != snap_valid) begin
          snap_valid_nxt  = valid;
          snap_symbol_nxt = symbol;
          line_idx_nxt    = '0;
          win_found_nxt   = 1'b0;
          block_found_nxt = 1'b0;
        end else begin
          if (!win_found && own_cnt == 2'd2 && has_empty) begin
            win_found_nxt = 1'b1;
            win_cell_nxt  = empty_cell;
          end
          if (!block_found && opp_cnt == 2'd2 && has_empty) begin
            block_found_nxt = 1'b1;
            block_cell_nxt  = empty_cell;
          end
          if (line_idx == 3'd7) state_nxt = S_PICK;
          else                  line_idx_nxt = line_idx + 3'd1;
        end
      end
      S_PICK: begin
        if (!playing || !pick_ok) begin
          state_nxt = S_IDLE;
        end else begin
          target_nxt = pick_cell;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!playing) begin
          state_nxt = S_IDLE;
        end else if (valid[target]) begin
          state_nxt       = S_SCAN;
          snap_valid_nxt  = valid;
          snap_symbol_nxt = symbol;
          line_idx_nxt    = '0;
          win_found_nxt   = 1'b0;
          block_found_nxt = 1'b0;
        end else begin
          state_nxt   = S_WAIT;
          tmo_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        if (valid[target]) begin
          move_done_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          error_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      snap_valid  <= '0;
      snap_symbol <= '0;
      line_idx    <= '0;
      win_found   <= 1'b0;
      block_found <= 1'b0;
      win_cell    <= '0;
      block_cell  <= '0;
      target      <= '0;
      tmo_cnt     <= '0;
      move_done   <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      snap_valid  <= snap_valid_nxt;
      snap_symbol <= snap_symbol_nxt;
      line_idx    <= line_idx_nxt;
      win_found   <= win_found_nxt;
      block_found <= block_found_nxt;
      win_cell    <= win_cell_nxt;
      block_cell  <= block_cell_nxt;
      target      <= target_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      move_done   <= move_done_nxt;
      error       <= error_nxt;
    end
  end

  assign busy = (state != S_IDLE);
  assign row  = (state == S_ISSUE || state == S_WAIT) ? idx_to_row(target) : 2'b00;
  assign col  = (state == S_ISSUE || state == S_WAIT) ? idx_to_col(target) : 2'b00;
  // Gated live so an abort or a slipped-in move never produces a strobe.
  assign set  = (state == S_ISSUE) && playing && !valid[target];

endmodule

// File: tb/tb_ttt_auto_player.sv
// Testbench for ttt_auto_player: two players (symbol 1 and symbol 0) share a
// bench-modelled board; moves are checked against a whole-board reference.
module tb_ttt_auto_player;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en_o, en_x;
  logic [8:0] valid, symbol;
  logic [1:0] game_state;
  logic [1:0] row_o, col_o, row_x, col_x;
  logic       set_o, busy_o, done_o, err_o;
  logic       set_x, busy_x, done_x, err_x;

  always #5 clk = ~clk;

  ttt_auto_player #(.MY_SYMBOL(1'b0), .TIMEOUT(TMO)) dut_o (
    .clk(clk), .reset_n(reset_n), .enable(en_o), .valid(valid), .symbol(symbol),
    .game_state(game_state), .row(row_o), .col(col_o), .set(set_o),
    .busy(busy_o), .move_done(done_o), .error(err_o)
  );

  ttt_auto_player #(.MY_SYMBOL(1'b1), .TIMEOUT(TMO)) dut_x (
    .clk(clk), .reset_n(reset_n), .enable(en_x), .valid(valid), .symbol(symbol),
    .game_state(game_state), .row(row_x), .col(col_x), .set(set_x),
    .busy(busy_x), .move_done(done_x), .error(err_x)
  );

  bit         sel;
  logic [1:0] m_row, m_col;
  logic       m_set, m_busy, m_done, m_err;
  assign m_row  = sel ? row_x  : row_o;
  assign m_col  = sel ? col_x  : col_o;
  assign m_set  = sel ? set_x  : set_o;
  assign m_busy = sel ? busy_x : busy_o;
  assign m_done = sel ? done_x : done_o;
  assign m_err  = sel ? err_x  : err_o;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int PREF [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  function automatic bit has_winner(input logic [8:0] v, input logic [8:0] s);
    for (int l = 0; l < 8; l++)
      if (v[LN[l][0]] && v[LN[l][1]] && v[LN[l][2]] &&
          s[LN[l][0]] == s[LN[l][1]] && s[LN[l][1]] == s[LN[l][2]])
        return 1'b1;
    return 1'b0;
  endfunction

  // Whole-board choice: any line I can complete, else any line the
  // opponent could complete, else the preference list.
  function automatic int ref_pick(input logic [8:0] v, input logic [8:0] s, input bit me);
    for (int pass = 0; pass < 2; pass++) begin
      for (int l = 0; l < 8; l++) begin
        int own = 0, opp = 0, ne = 0, emp = -1;
        for (int k = 0; k < 3; k++) begin
          int c = LN[l][k];
          if (!v[c]) begin ne++; emp = c; end
          else if (s[c] == me) own++;
          else opp++;
        end
        if (ne == 1 && ((pass == 0 && own == 2) || (pass == 1 && opp == 2)))
          return emp;
      end
    end
    for (int i = 0; i < 9; i++)
      if (!v[PREF[i]]) return PREF[i];
    return -1;
  endfunction

  // Random legal position (X moves first), no winner yet, not full.
  task automatic make_board(output logic [8:0] v, output logic [8:0] s, output bit mover);
    bit ok;
    int k, c;
    v = '0; s = '0; mover = 1'b1;
    for (int attempt = 0; attempt < 200; attempt++) begin
      k = $urandom_range(0, 7);
      v = '0; s = '0; ok = 1'b1;
      for (int m = 0; m < k && ok; m++) begin
        do c = $urandom_range(0, 8); while (v[c]);
        v[c] = 1'b1;
        s[c] = (m % 2 == 0);
        if (has_winner(v, s)) ok = 1'b0;
      end
      if (ok) begin
        mover = (k % 2 == 0);
        return;
      end
    end
    v = '0; s = '0; mover = 1'b1;
  endtask

  task automatic play_move(input bit who, input int exp_cell, input int ack_dly, input bit do_ack);
    int lat;
    bit seen_done;
    sel = who;
    if (who) en_x = 1'b1; else en_o = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (n == 1) begin
        en_x = 1'b0; en_o = 1'b0;
        check("busy_scan", m_busy, 1);
        check("rowcol_scan", {m_row, m_col}, 0);
      end
      if (m_set) lat = n;
    end
    check("set_latency", lat, 10);
    if (lat < 0) return;
    check("row", m_row, exp_cell / 3 + 1);
    check("col", m_col, exp_cell % 3 + 1);
    if (do_ack) begin
      for (int d = 0; d < ack_dly; d++) begin
        tick();
        if (d == 0) begin
          check("set_one_cycle", m_set, 0);
          check("row_held", m_row, exp_cell / 3 + 1);
        end
      end
      valid[exp_cell]  = 1'b1;
      symbol[exp_cell] = who;
      tick();
      check("move_done", m_done, 1);
      check("busy_done", m_busy, 0);
      tick();
      check("done_pulse", m_done, 0);
    end else begin
      seen_done = 1'b0;
      for (int n = 1; n <= TMO; n++) begin
        tick();
        seen_done |= m_done;
      end
      check("err_early", m_err, 0);
      tick();
      check("error", m_err, 1);
      check("busy_timeout", m_busy, 0);
      check("rowcol_timeout", {m_row, m_col}, 0);
      check("no_done", int'(seen_done | m_done), 0);
    end
  endtask

  initial begin
    logic [8:0] v, s;
    bit mover;
    int exp;
    bit set_seen;

    reset_n = 1'b0; en_o = 1'b0; en_x = 1'b0;
    valid = '0; symbol = '0; game_state = 2'b00; sel = 1'b0;
    tick(); tick();
    for (int w = 0; w < 2; w++) begin
      sel = (w == 1);
      #0;
      check("rst_rowcol", {m_row, m_col}, 0);
      check("rst_set", m_set, 0);
      check("rst_busy", m_busy, 0);
      check("rst_done", m_done, 0);
      check("rst_err", m_err, 0);
    end
    @(negedge clk); reset_n = 1'b1;
    tick();

    // Empty board, first mover takes the centre.
    play_move(1'b1, 4, 2, 1'b1);
    tick();

    // Block: X at 0,1, O at 4.
    valid = 9'b000010011; symbol = 9'b000000011;
    play_move(1'b0, 2, 1, 1'b1);
    tick();

    // Win beats block: O at 3,4, X at 0,1,8.
    valid = 9'b100011011; symbol = 9'b100000011;
    play_move(1'b0, 5, 3, 1'b1);
    tick();

    for (int it = 0; it < 30; it++) begin
      make_board(v, s, mover);
      valid = v; symbol = s;
      exp = ref_pick(v, s, mover);
      play_move(mover, exp, $urandom_range(1, 5), 1'b1);
      tick();
    end

    // Board never acknowledges.
    valid = 9'b000000001; symbol = 9'b000000001;
    play_move(1'b0, 4, 0, 1'b0);
    tick();

    // Game ends during SCAN.
    sel = 1'b0;
    en_o = 1'b1;
    tick(); en_o = 1'b0;
    tick(); tick();
    game_state = 2'b01;
    set_seen = 1'b0;
    tick();
    check("abort_idle", m_busy, 0);
    for (int n = 0; n < 12; n++) begin
      tick();
      set_seen |= m_set;
    end
    check("abort_no_set", int'(set_seen), 0);
    check("abort_rowcol", {m_row, m_col}, 0);
    game_state = 2'b00;
    tick();

    // Reset pulsed during WAIT (error still set from the timeout case).
    check("err_sticky", m_err, 1);
    en_o = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) en_o = 1'b0;
    end
    check("wait_busy", m_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", m_busy, 0);
    check("arst_rowcol", {m_row, m_col}, 0);
    check("arst_set", m_set, 0);
    check("arst_err", m_err, 0);
    check("arst_done", m_done, 0);
    @(negedge clk); reset_n = 1'b1;
    tick(); tick();
    check("post_rst_busy", m_busy, 0);
    check("post_rst_err", m_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
